// File: rtl/rc_sample_scheduler_pkg.sv
// rtl/rc_sample_scheduler_pkg.sv - shared FSM encodings and round-robin pick function for the RC sample scheduler
package rc_sample_scheduler_pkg;

   localparam int MAX_REQ   = 8;
   localparam int MAX_IDX_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   // Descending walk so the nearest pending index after 'last' is written last and wins.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] pending, input int last, input int total);
      int idx;
      rr_pick = last;
      for (int k = MAX_REQ; k >= 1; k--) begin
         if (k <= total) begin
            idx = (last + k) % total;
            if (pending[idx[MAX_IDX_W-1:0]])
               rr_pick = idx;
         end
      end
   endfunction

endpackage

// File: rtl/rc_sample_scheduler_if.sv
// rtl/rc_sample_scheduler_if.sv - outbound report channel between the scheduler and the host-facing write channel
interface rc_sample_scheduler_if #(
   parameter int WIDTH = 17,
   parameter int SEL_W = 3
);
   logic [WIDTH-1:0] bus_out;
   logic [SEL_W-1:0] out_selected;
   logic             out_stb;
   logic             out_rdy;

   modport master (output bus_out, output out_selected, output out_stb, input out_rdy);
   modport slave  (input bus_out, input out_selected, input out_stb, output out_rdy);
endinterface

// File: rtl/rc_sample_scheduler_rr_pick.sv
// rtl/rc_sample_scheduler_rr_pick.sv - combinational round-robin priority encoder (module rc_rr_pick)
module rc_rr_pick
   import rc_sample_scheduler_pkg::*;
#(
   parameter int TOTAL = 7,
   parameter int SEL_W = 3
) (
   input  logic [TOTAL-1:0] pending,
   input  logic [SEL_W-1:0] last_grant,
   output logic [SEL_W-1:0] grant,
   output logic             valid
);

   always_comb begin
      valid = |pending;
      grant = SEL_W'(rr_pick(MAX_REQ'(pending), int'(last_grant), TOTAL));
   end

endmodule

// File: rtl/rc_sample_scheduler.sv
// rtl/rc_sample_scheduler.sv - round-robin share of the RC report channel with one-deep slots; RC_SCHED_OVERWRITE_EN keeps newest sample on overrun
module rc_sample_scheduler
   import rc_sample_scheduler_pkg::*;
#(
   parameter int TOTAL = 7,
   parameter int WIDTH = 17,
   parameter int SEL_W = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [TOTAL-1:0]       rdy,
   input  logic [TOTAL*WIDTH-1:0] bus_in,
   input  logic [TOTAL-1:0]       enable,
   rc_sample_scheduler_if.master  out_if,
   output logic [TOTAL-1:0]       overrun,
   input  logic                   overrun_clr,
   output logic                   busy
);

   state_t           state;
   logic [TOTAL-1:0] pending;
   logic [WIDTH-1:0] hold [TOTAL];
   logic [SEL_W-1:0] last_grant;
   logic [SEL_W-1:0] pick;
   logic             pick_valid;
   logic [TOTAL-1:0] cap;
   logic [TOTAL-1:0] grant_now;

   // Disabled slots are never granted; their pending bit clears on the same edge.
   rc_rr_pick #(.TOTAL(TOTAL), .SEL_W(SEL_W)) u_rr_pick (
      .pending    (pending & enable),
      .last_grant (last_grant),
      .grant      (pick),
      .valid      (pick_valid)
   );

   always_comb begin
      cap       = rdy & enable;
      grant_now = '0;
      for (int i = 0; i < TOTAL; i++)
         grant_now[i] = (state == ST_IDLE) && pick_valid && (pick == SEL_W'(i));
   end

   assign busy = out_if.out_stb | (|pending);

   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= ST_IDLE;
         out_if.out_stb      <= 1'b0;
         out_if.bus_out      <= '0;
         out_if.out_selected <= '0;
         last_grant          <= SEL_W'(TOTAL - 1);
         pending             <= '0;
         overrun             <= '0;
         for (int i = 0; i < TOTAL; i++)
            hold[i] <= '0;
      end else begin
         for (int i = 0; i < TOTAL; i++) begin
            if (!enable[i]) begin
               pending[i] <= 1'b0;
            end else if (rdy[i]) begin
               if (!pending[i] || grant_now[i]) begin
                  hold[i]    <= bus_in[WIDTH*i +: WIDTH];
                  pending[i] <= 1'b1;
               end
`ifdef RC_SCHED_OVERWRITE_EN
               else hold[i] <= bus_in[WIDTH*i +: WIDTH];
`else
               else hold[i] <= hold[i];
`endif
            end else if (grant_now[i]) begin
               pending[i] <= 1'b0;
            end
            // A new overrun in the same cycle as a clear takes precedence.
            if (overrun_clr)
               overrun[i] <= 1'b0;
            if (cap[i] && pending[i] && !grant_now[i])
               overrun[i] <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  out_if.bus_out      <= hold[pick];
                  out_if.out_selected <= pick;
                  out_if.out_stb      <= 1'b1;
                  last_grant          <= pick;
                  state               <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (out_if.out_rdy) begin
                  out_if.out_stb <= 1'b0;
                  state          <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
